// File: rtl/sb_rx_deframer.sv
// Sideband receive front end: oversampled UART symbol recovery followed by
// DLE/STX/ETX de-framing with byte-stuffing removal. Payload bytes leave
// through a one-deep hold register so the final byte can be tagged with EOP.
module sb_rx_deframer #(
  parameter int         OSR       = 5,
  parameter logic [7:0] DLE       = 8'hFE,
  parameter logic [7:0] STX       = 8'h05,
  parameter logic [7:0] ETX       = 8'h40,
  parameter int         LOW_LIMIT = 50
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       sym_err,
  output logic       frame_err,
  output logic       sbrx_low
);

  localparam int CW   = $clog2(OSR);
  localparam int HALF = (OSR - 1) / 2;
  localparam int LW   = $clog2(LOW_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} sym_st_t;
  typedef enum logic [1:0] {F_IDLE, F_HDR_DLE, F_BODY, F_BODY_DLE} frm_st_t;

  logic [1:0]    r_sync;
  logic          w_s;
  logic          r_s_prev;
  sym_st_t       r_sst;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_byte_stb;
  logic          r_sym_evt;
  frm_st_t       r_fst;
  logic          r_sop_pend;
  logic          r_hold_vld;
  logic          r_hold_sop;
  logic [7:0]    r_hold_byte;
  logic [LW-1:0] r_low_cnt;
  logic          w_push;

  assign w_s = r_sync[1];

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], sbrx};
  end

  // Symbol recovery: find start edge, sample mid start bit, then every OSR.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_sst      <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_byte_stb <= 1'b0;
      r_sym_evt  <= 1'b0;
      r_s_prev   <= 1'b1;
    end else begin
      r_s_prev   <= w_s;
      r_byte_stb <= 1'b0;
      r_sym_evt  <= 1'b0;
      case (r_sst)
        S_IDLE: begin
          if (!w_s && r_s_prev) begin
            r_sst <= S_START;
            r_cnt <= '0;
          end
        end
        S_START: begin
          if (r_cnt == CW'(HALF)) begin
            r_cnt <= '0;
            r_idx <= '0;
            // A line that is high again mid start bit was only a glitch.
            r_sst <= w_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CW'(OSR - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_s, r_shift[7:1]};
            if (r_idx == 3'd7) r_sst <= S_STOP;
            else               r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == CW'(OSR - 1)) begin
            r_cnt <= '0;
            if (w_s) begin
              r_byte_stb <= 1'b1;
              r_sst      <= S_IDLE;
            end else begin
              r_sym_evt  <= 1'b1;
              r_sst      <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: if (w_s) r_sst <= S_IDLE;
        default:     r_sst <= S_IDLE;
      endcase
    end
  end

  // A payload byte is either a plain body byte or an escaped DLE; both equal r_shift.
  assign w_push = r_byte_stb &&
                  (((r_fst == F_BODY) && (r_shift != DLE)) ||
                   ((r_fst == F_BODY_DLE) && (r_shift == DLE)));

  // Framing FSM plus hold register; all outputs registered here.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_fst       <= F_IDLE;
      r_sop_pend  <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_sop  <= 1'b0;
      r_hold_byte <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      rx_sop      <= 1'b0;
      rx_eop      <= 1'b0;
      sym_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_sop    <= 1'b0;
      rx_eop    <= 1'b0;
      sym_err   <= 1'b0;
      frame_err <= 1'b0;

      if (w_push) begin
        if (r_hold_vld) begin
          rx_valid <= 1'b1;
          rx_byte  <= r_hold_byte;
          rx_sop   <= r_hold_sop;
        end
        r_hold_byte <= r_shift;
        r_hold_sop  <= r_sop_pend;
        r_hold_vld  <= 1'b1;
        r_sop_pend  <= 1'b0;
      end

      if (r_sym_evt) begin
        sym_err <= 1'b1;
        // A corrupted byte inside a frame poisons the whole frame.
        if (r_fst != F_IDLE) begin
          frame_err  <= 1'b1;
          r_fst      <= F_IDLE;
          r_hold_vld <= 1'b0;
          r_sop_pend <= 1'b0;
        end
      end else if (r_byte_stb) begin
        case (r_fst)
          F_IDLE:    if (r_shift == DLE) r_fst <= F_HDR_DLE;
          F_HDR_DLE: begin
            if (r_shift == STX) begin
              r_fst      <= F_BODY;
              r_sop_pend <= 1'b1;
            end else if (r_shift != DLE) begin
              r_fst <= F_IDLE;
            end
          end
          F_BODY:    if (r_shift == DLE) r_fst <= F_BODY_DLE;
          F_BODY_DLE: begin
            if (r_shift == DLE) begin
              r_fst <= F_BODY;
            end else if (r_shift == ETX) begin
              r_fst      <= F_IDLE;
              r_sop_pend <= 1'b0;
              r_hold_vld <= 1'b0;
              if (r_hold_vld) begin
                rx_valid <= 1'b1;
                rx_byte  <= r_hold_byte;
                rx_sop   <= r_hold_sop;
                rx_eop   <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (r_shift == STX) begin
              // Back-to-back restart: abandon the open frame, begin a new body.
              frame_err  <= 1'b1;
              r_hold_vld <= 1'b0;
              r_sop_pend <= 1'b1;
              r_fst      <= F_BODY;
            end else begin
              frame_err  <= 1'b1;
              r_hold_vld <= 1'b0;
              r_sop_pend <= 1'b0;
              r_fst      <= F_IDLE;
            end
          end
          default: r_fst <= F_IDLE;
        endcase
      end
    end
  end

  // Sustained-low detector: saturating count of consecutive low samples.
  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      r_low_cnt <= '0;
      sbrx_low  <= 1'b0;
    end else if (w_s) begin
      r_low_cnt <= '0;
      sbrx_low  <= 1'b0;
    end else if (r_low_cnt != LW'(LOW_LIMIT)) begin
      r_low_cnt <= r_low_cnt + 1'b1;
      sbrx_low  <= (r_low_cnt == LW'(LOW_LIMIT - 1));
    end
  end

endmodule
